bs_fm0_encoder: RTL and testbench

BS_FM0_ENCODER -- requirements
Module: bs_fm0_encoder

---
 rtl/bs_pkg.sv | 24 ++
 rtl/bs_tick_gen.sv | 30 +++
 rtl/bs_fm0_encoder.sv | 159 +++++++++++++++
 tb/tb_bs_fm0_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared types and defaults for the FM0 backscatter encoder
// Holds the frame state enum, default half-bit divider and preamble,
// counter widths and the len-to-byte-count helper.
package bs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_EOF,
    ST_DONE
  } bs_state_t;

  localparam int          CLK_DIV_DEF  = 100;
  localparam logic [7:0]  PREAMBLE_DEF = 8'b1010_1100;
  localparam int          LEN_W        = 4;
  localparam int          CNT_W        = 5;

  // A len field of zero encodes a full 16-byte payload.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] l);
    return (l == '0) ? CNT_W'(16) : CNT_W'(l);
  endfunction

endpackage

// File: rtl/bs_tick_gen.sv
// rtl/bs_tick_gen.sv - half-bit tick counter with synchronous restart
// Ports: clk, rst_n (sync, active-low), restart (zero the count),
// en (count enable), tick (high for one cycle every DIV enabled clocks).
module bs_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bs_fm0_encoder.sv
// rtl/bs_fm0_encoder.sv - FM0 frame encoder: preamble, payload bytes, dummy-1 EOF
// Ports: clk, rst_n (sync, active-low); start/len request a frame;
// in_data/in_valid/in_ready feed payload bytes; mod_out is the FM0 level,
// mod_en gates the modulator; busy, done (normal end), err (underflow).
module bs_fm0_encoder
  import bs_pkg::*;
#(
  parameter int         CLK_DIV  = CLK_DIV_DEF,
  parameter logic [7:0] PREAMBLE = PREAMBLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mod_out,
  output logic             mod_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  bs_state_t        state, state_n;
  logic             tick, half, uflow, underflow, load;
  logic             buf_full, mod_out_q;
  logic [2:0]       bitcnt;
  logic [CNT_W-1:0] fetched, sent, len_eff;
  logic [7:0]       buf_q, shreg;
  logic             accept, active, bit_end, byte_end, cur_bit, take;

  assign accept   = (state == ST_IDLE) && start;
  assign active   = (state == ST_PREAMBLE) || (state == ST_DATA) || (state == ST_EOF);
  assign bit_end  = tick && half;
  assign byte_end = bit_end && (bitcnt == 3'd7);
  // Preamble and payload both live in shreg; EOF is a constant 1.
  assign cur_bit  = (state == ST_EOF) ? 1'b1 : shreg[3'd7 - bitcnt];
  assign in_ready = active && !buf_full && (fetched < len_eff);
  assign take     = in_valid && in_ready;
  assign mod_out  = mod_out_q;

  bs_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .en      (active),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    underflow = 1'b0;
    busy      = 1'b1;
    mod_en    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_n = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        mod_en = 1'b1;
        if (byte_end) begin
          if (buf_full) begin
            load    = 1'b1;
            state_n = ST_DATA;
          end else begin
            underflow = 1'b1;
            state_n   = ST_DONE;
          end
        end
      end
      ST_DATA: begin
        mod_en = 1'b1;
        if (byte_end) begin
          if (sent == len_eff) begin
            state_n = ST_EOF;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            underflow = 1'b1;
            state_n   = ST_DONE;
          end
        end
      end
      ST_EOF: begin
        mod_en = 1'b1;
        if (bit_end) state_n = ST_DONE;
      end
      ST_DONE: begin
        // The DONE cycle doubles as the underflow cycle; uflow selects the pulse.
        done    = !uflow;
        err     = uflow;
        state_n = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uflow     <= 1'b0;
      half      <= 1'b0;
      bitcnt    <= '0;
      fetched   <= '0;
      sent      <= '0;
      len_eff   <= '0;
      buf_q     <= '0;
      buf_full  <= 1'b0;
      shreg     <= '0;
      mod_out_q <= 1'b0;
    end else begin
      uflow <= underflow;
      if (accept) begin
        len_eff   <= len_to_count(len);
        fetched   <= '0;
        sent      <= '0;
        buf_full  <= 1'b0;
        half      <= 1'b0;
        bitcnt    <= '0;
        shreg     <= PREAMBLE;
        mod_out_q <= 1'b1;  // first bit start inverts the idle 0
      end else begin
        if (take) begin
          buf_q    <= in_data;
          buf_full <= 1'b1;
          fetched  <= fetched + CNT_W'(1);
        end
        if (load) begin
          shreg    <= buf_q;
          buf_full <= 1'b0;
          sent     <= sent + CNT_W'(1);
        end
        if (tick) begin
          half <= ~half;
          if (!half) begin
            if (!cur_bit) mod_out_q <= ~mod_out_q;
          end else begin
            bitcnt    <= bitcnt + 3'd1;
            mod_out_q <= ~mod_out_q;
          end
        end
        if ((state_n == ST_DONE) || (state_n == ST_IDLE)) mod_out_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bs_fm0_encoder.sv
// tb/tb_bs_fm0_encoder.sv - self-checking bench for bs_fm0_encoder
module tb_bs_fm0_encoder;

  localparam int         D   = 4;
  localparam logic [7:0] PRE = 8'b1010_1100;
  localparam int         MAXN = 1200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, mod_out, mod_en, busy, done, err;

  bs_fm0_encoder #(.CLK_DIV(D), .PREAMBLE(PRE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mod_out  (mod_out),
    .mod_en   (mod_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs, indexed by cycles after the start edge.
  bit exp_mo [MAXN];
  bit exp_en [MAXN];
  bit exp_bz [MAXN];
  bit exp_dn [MAXN];
  bit exp_er [MAXN];
  bit exp_r0 [MAXN];
  int exp_total;
  logic [15:0] model_pre;
  logic [7:0]  bytes [16];

  int j = 0;
  bit cmp_on = 1'b0;
  bit stop_feed = 1'b0;
  int hs = 0;
  int first_done = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, j, act, exp);
    end
  endtask

  // FM0 from first principles: level inverts at each bit start, and again
  // halfway through a 0 bit. Output is zero outside the frame.
  task automatic build_exp(input int le, input int abort_bits, input int cut);
    bit bq[$];
    bit hv[$];
    bit lvl;
    bit uf;
    logic [7:0] p;
    int nb;
    p = PRE;
    for (int i = 7; i >= 0; i--) bq.push_back(p[i]);
    for (int b = 0; b < le; b++)
      for (int i = 7; i >= 0; i--) bq.push_back(bytes[b][i]);
    bq.push_back(1'b1);
    uf = (abort_bits >= 0);
    if (uf) while (bq.size() > abort_bits) void'(bq.pop_back());
    nb = bq.size();
    lvl = 1'b0;
    for (int k = 0; k < nb; k++) begin
      lvl = ~lvl;
      hv.push_back(lvl);
      if (!bq[k]) lvl = ~lvl;
      hv.push_back(lvl);
    end
    for (int k = 0; k < 16; k++) model_pre[15-k] = hv[k];
    for (int n = 0; n < MAXN; n++) begin
      exp_mo[n] = 0; exp_en[n] = 0; exp_bz[n] = 0;
      exp_dn[n] = 0; exp_er[n] = 0; exp_r0[n] = 1;
    end
    for (int n = 0; n < nb * 2 * D; n++) begin
      exp_mo[n] = hv[n / D];
      exp_en[n] = 1;
      exp_bz[n] = 1;
      exp_r0[n] = 0;
    end
    exp_bz[nb*2*D] = 1;
    exp_dn[nb*2*D] = !uf;
    exp_er[nb*2*D] = uf;
    exp_total = nb * 2 * D + 2;
    if (cut >= 0 && cut < exp_total) begin
      for (int n = cut; n < cut + 3; n++) begin
        exp_mo[n] = 0; exp_en[n] = 0; exp_bz[n] = 0;
        exp_dn[n] = 0; exp_er[n] = 0; exp_r0[n] = 1;
      end
      exp_total = cut + 3;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      if (j < exp_total) begin
        chk("mod_out", 32'(mod_out), 32'(exp_mo[j]));
        chk("mod_en",  32'(mod_en),  32'(exp_en[j]));
        chk("busy",    32'(busy),    32'(exp_bz[j]));
        chk("done",    32'(done),    32'(exp_dn[j]));
        chk("err",     32'(err),     32'(exp_er[j]));
        if (exp_r0[j]) chk("in_ready_low", 32'(in_ready), 32'd0);
        if (in_valid && in_ready) hs++;
        if (done && first_done < 0) first_done = j;
        j++;
      end else begin
        cmp_on = 1'b0;
      end
    end
  end

  // mode: 0 normal, 1 valid gaps, 2 withhold after first byte,
  //       3 extra start at clock 50, 4 reset at clock 70
  task automatic run_frame(input logic [3:0] l, input int mode, input int fill);
    int le, nfeed;
    le = (l == 4'd0) ? 16 : int'(l);
    for (int i = 0; i < 16; i++) bytes[i] = (fill < 0) ? 8'($urandom) : 8'(fill);
    nfeed = (mode == 2) ? 1 : le;
    build_exp(le, (mode == 2) ? 16 : -1, (mode == 4) ? 70 : -1);
    hs = 0;
    first_done = -1;
    stop_feed = 1'b0;
    @(posedge clk); #1;
    len = l;
    start = 1'b1;
    @(posedge clk);
    j = 0;
    cmp_on = 1'b1;
    #1 start = 1'b0;
    fork
      begin
        for (int i = 0; i < nfeed && !stop_feed; i++) begin
          int g;
          in_data = bytes[i];
          if (mode == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 10)) @(posedge clk);
            #1;
          end
          in_valid = 1'b1;
          g = 0;
          do begin
            @(negedge clk);
            g++;
          end while (!in_ready && !stop_feed && g < 3000);
          if (g >= 3000) begin
            checks++; errors++;
            $display("FAIL feed_timeout byte %0d", i);
          end
          @(posedge clk); #1;
        end
        in_data = 8'h5A;
        in_valid = (mode == 2 || mode == 4) ? 1'b0 : 1'b1;
      end
      begin
        if (mode == 3) begin
          repeat (49) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end else if (mode == 4) begin
          repeat (69) @(posedge clk);
          #1 rst_n = 1'b0;
          @(posedge clk);
          #1 rst_n = 1'b1;
          stop_feed = 1'b1;
        end
      end
      begin
        int g = 0;
        while (cmp_on && g < 3000) begin
          @(negedge clk);
          g++;
        end
        if (cmp_on) begin
          checks++; errors++;
          $display("FAIL frame_timeout got %0d cycles expected %0d", j, exp_total);
          cmp_on = 1'b0;
        end
      end
    join
    in_valid = 1'b0;
    if (mode != 4) chk("handshakes", 32'(hs), 32'(nfeed));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mod_out",  32'(mod_out),  32'd0);
    chk("rst_mod_en",   32'(mod_en),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // len=1, 0xFF: the model itself is pinned by hand-computed values
    run_frame(4'd1, 0, 8'hFF);
    chk("model_preamble_halves", 32'(model_pre), 32'h0000D2CA);
    chk("model_len1_total", 32'(exp_total), 32'd138);
    chk("len1_done_clocks", 32'(first_done), 32'd136);

    run_frame(4'd1, 0, 8'h00);
    run_frame(4'd2, 2, -1);
    run_frame(4'd3, 3, -1);
    chk("restart_done_clocks", 32'(first_done), 32'((9 + 24) * 8));
    run_frame(4'd4, 4, -1);
    run_frame(4'd1, 0, -1);
    chk("after_reset_done", 32'(first_done), 32'd136);
    run_frame(4'd0, 1, -1);
    chk("len0_done_clocks", 32'(first_done), 32'd1096);
    for (int r = 0; r < 6; r++)
      run_frame(4'($urandom_range(1, 6)), int'($urandom_range(0, 1)), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
